// File: rtl/gray_cnt_sequencer.sv
// Command-driven Gray-code counter: STOP/RUN/STEP/LOAD over valid/ready, prescaled advance in RUN.
// Outputs registered (gray derived combinationally); cmd_ready drops only during the one-cycle STEP state.
`timescale 1ns/1ps
module gray_cnt_sequencer #(
   parameter int unsigned TICK_DIV = 50000000,
   parameter int          CNT_W    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [CNT_W-1:0] cmd_arg,
   output logic [CNT_W-1:0] o_bin,
   output logic [CNT_W-1:0] o_gray,
   output logic             o_tick,
   output logic             o_wrap,
   output logic             o_busy
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP} state_t;

   localparam logic [1:0]       OP_STOP = 2'b00;
   localparam logic [1:0]       OP_RUN  = 2'b01;
   localparam logic [1:0]       OP_STEP = 2'b10;
   localparam logic [1:0]       OP_LOAD = 2'b11;
   localparam logic [31:0]      L_TERM  = 32'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] L_ONE   = CNT_W'(1);

   state_t           r_state, w_state_nxt;
   logic [31:0]      r_presc, w_presc_nxt;
   logic             r_dir, w_dir_nxt;
   logic [CNT_W-1:0] r_bin, w_bin_nxt;
   logic             r_tick, w_tick_nxt;
   logic             r_wrap, w_wrap_nxt;
   logic             w_accept;
   logic [CNT_W-1:0] w_adv_bin;
   logic             w_adv_wrap;

   assign cmd_ready  = (r_state != S_STEP);
   assign w_accept   = cmd_valid && cmd_ready;
   assign w_adv_bin  = r_dir ? (r_bin - L_ONE) : (r_bin + L_ONE);
   assign w_adv_wrap = r_dir ? (r_bin == '0) : (r_bin == '1);

   assign o_bin  = r_bin;
   assign o_gray = r_bin ^ (r_bin >> 1);
   assign o_tick = r_tick;
   assign o_wrap = r_wrap;
   assign o_busy = (r_state == S_RUN) || (r_state == S_STEP);

   always_comb begin
      w_state_nxt = r_state;
      w_presc_nxt = r_presc;
      w_dir_nxt   = r_dir;
      w_bin_nxt   = r_bin;
      w_tick_nxt  = 1'b0;
      w_wrap_nxt  = 1'b0;

      case (r_state)
         S_RUN: begin
            if (r_presc == L_TERM) begin
               w_presc_nxt = '0;
               w_bin_nxt   = w_adv_bin;
               w_tick_nxt  = 1'b1;
               w_wrap_nxt  = w_adv_wrap;
            end else begin
               w_presc_nxt = r_presc + 32'd1;
            end
         end
         S_STEP: begin
            w_state_nxt = S_IDLE;
            w_presc_nxt = '0;
            w_bin_nxt   = w_adv_bin;
            w_tick_nxt  = 1'b1;
            w_wrap_nxt  = w_adv_wrap;
         end
         default: begin
            w_presc_nxt = '0;
         end
      endcase

      // An accepted command overrides any advance scheduled for this edge.
      if (w_accept) begin
         w_tick_nxt  = 1'b0;
         w_wrap_nxt  = 1'b0;
         w_bin_nxt   = r_bin;
         w_presc_nxt = '0;
         case (cmd_op)
            OP_STOP: w_state_nxt = S_IDLE;
            OP_RUN: begin
               w_dir_nxt   = cmd_arg[0];
               w_state_nxt = S_RUN;
            end
            OP_STEP: begin
               w_dir_nxt   = cmd_arg[0];
               w_state_nxt = S_STEP;
            end
            OP_LOAD: w_bin_nxt = cmd_arg;
            default: w_state_nxt = r_state;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_presc <= '0;
         r_dir   <= 1'b0;
         r_bin   <= '0;
         r_tick  <= 1'b0;
         r_wrap  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_presc <= w_presc_nxt;
         r_dir   <= w_dir_nxt;
         r_bin   <= w_bin_nxt;
         r_tick  <= w_tick_nxt;
         r_wrap  <= w_wrap_nxt;
      end
   end

endmodule

// File: tb/tb_gray_cnt_sequencer.sv
// Directed bench for gray_cnt_sequencer with TICK_DIV=4; expected advances are queued and matched on o_tick.
`timescale 1ns/1ps
module tb_gray_cnt_sequencer;

   localparam logic [1:0] OP_STOP = 2'b00;
   localparam logic [1:0] OP_RUN  = 2'b01;
   localparam logic [1:0] OP_STEP = 2'b10;
   localparam logic [1:0] OP_LOAD = 2'b11;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = 2'b00;
   logic [3:0] cmd_arg = 4'd0;
   logic [3:0] o_bin, o_gray;
   logic       o_tick, o_wrap, o_busy;

   typedef struct packed {
      logic [3:0] bin;
      logic [3:0] gray;
      logic       wrap;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   logic [3:0] gray_tbl [16];

   gray_cnt_sequencer #(.TICK_DIV(4), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_arg(cmd_arg), .o_bin(o_bin), .o_gray(o_gray),
      .o_tick(o_tick), .o_wrap(o_wrap), .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [3:0] b, input logic w);
      exp_t e;
      e.bin  = b;
      e.gray = gray_tbl[b];
      e.wrap = w;
      sb.push_back(e);
   endtask

   // One clock; any advance strobe is matched against the head of the scoreboard.
   task automatic cyc();
      exp_t e;
      @(posedge clk);
      #1;
      if (o_tick) begin
         if (sb.size() == 0) begin
            chk("tick_unexpected", {31'b0, o_tick}, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("adv_bin", {28'b0, o_bin}, {28'b0, e.bin});
            chk("adv_gray", {28'b0, o_gray}, {28'b0, e.gray});
            chk("adv_wrap", {31'b0, o_wrap}, {31'b0, e.wrap});
         end
      end else begin
         chk("wrap_without_tick", {31'b0, o_wrap}, 32'd0);
      end
   endtask

   task automatic send(input logic [1:0] op, input logic [3:0] arg);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_arg   = arg;
      cyc();
      cmd_valid = 1'b0;
   endtask

   task automatic drained(input string tag);
      chk(tag, sb.size(), 32'd0);
   endtask

   initial begin
      gray_tbl = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                   4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

      // Reset and idle
      rst_n = 1'b0;
      cyc(); cyc();
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cyc();
         chk("idle_bin", {28'b0, o_bin}, 32'd0);
         chk("idle_gray", {28'b0, o_gray}, 32'd0);
         chk("idle_tick", {31'b0, o_tick}, 32'd0);
         chk("idle_busy", {31'b0, o_busy}, 32'd0);
         chk("idle_ready", {31'b0, cmd_ready}, 32'd1);
      end

      // RUN up for 16 advances, one every 4 edges
      for (int i = 1; i <= 16; i++) push(4'(i % 16), i == 16);
      send(OP_RUN, 4'd0);
      chk("run_busy", {31'b0, o_busy}, 32'd1);
      for (int k = 1; k <= 16; k++) begin
         for (int j = 0; j < 3; j++) begin
            cyc();
            chk("run_no_tick", {31'b0, o_tick}, 32'd0);
         end
         cyc();
         chk("run_tick", {31'b0, o_tick}, 32'd1);
      end
      drained("run_up_drained");
      send(OP_STOP, 4'd0);
      chk("stop_busy", {31'b0, o_busy}, 32'd0);
      chk("stop_bin", {28'b0, o_bin}, 32'd0);

      // LOAD 0 then RUN down: 0 -> 15 wraps, 15 -> 14 does not
      send(OP_LOAD, 4'd0);
      push(4'd15, 1'b1);
      push(4'd14, 1'b0);
      send(OP_RUN, 4'd1);
      for (int i = 0; i < 8; i++) cyc();
      drained("run_down_drained");
      chk("run_down_bin", {28'b0, o_bin}, 32'd14);
      send(OP_STOP, 4'd0);

      // STEP from IDLE at 5, with a LOAD held across the STEP cycle
      send(OP_LOAD, 4'd5);
      chk("load5_bin", {28'b0, o_bin}, 32'd5);
      chk("load5_gray", {28'b0, o_gray}, 32'b0111);
      chk("load5_tick", {31'b0, o_tick}, 32'd0);
      push(4'd6, 1'b0);
      cmd_valid = 1'b1; cmd_op = OP_STEP; cmd_arg = 4'd0;
      cyc();
      chk("step_ready_low", {31'b0, cmd_ready}, 32'd0);
      chk("step_busy", {31'b0, o_busy}, 32'd1);
      chk("step_bin_held", {28'b0, o_bin}, 32'd5);
      cmd_op = OP_LOAD; cmd_arg = 4'd12;
      cyc();
      chk("step_bin", {28'b0, o_bin}, 32'd6);
      chk("step_tick", {31'b0, o_tick}, 32'd1);
      chk("step_ready_back", {31'b0, cmd_ready}, 32'd1);
      chk("step_idle", {31'b0, o_busy}, 32'd0);
      cyc();
      cmd_valid = 1'b0;
      chk("held_load_bin", {28'b0, o_bin}, 32'd12);
      drained("step_drained");

      // STOP on the terminal-count edge suppresses the advance
      send(OP_LOAD, 4'd3);
      send(OP_RUN, 4'd0);
      cyc(); cyc(); cyc();
      send(OP_STOP, 4'd0);
      chk("tc_stop_bin", {28'b0, o_bin}, 32'd3);
      chk("tc_stop_tick", {31'b0, o_tick}, 32'd0);
      chk("tc_stop_busy", {31'b0, o_busy}, 32'd0);
      for (int i = 0; i < 8; i++) cyc();
      chk("tc_stop_hold", {28'b0, o_bin}, 32'd3);

      // LOAD on the terminal-count edge wins, next advance one full period later
      send(OP_RUN, 4'd0);
      cyc(); cyc(); cyc();
      send(OP_LOAD, 4'd9);
      chk("tc_load_bin", {28'b0, o_bin}, 32'd9);
      chk("tc_load_tick", {31'b0, o_tick}, 32'd0);
      chk("tc_load_busy", {31'b0, o_busy}, 32'd1);
      push(4'd10, 1'b0);
      for (int j = 0; j < 3; j++) begin
         cyc();
         chk("tc_load_wait", {31'b0, o_tick}, 32'd0);
      end
      cyc();
      chk("tc_load_next", {28'b0, o_bin}, 32'd10);
      drained("tc_load_drained");
      send(OP_STOP, 4'd0);

      // Reset mid-period in RUN at 7
      send(OP_LOAD, 4'd7);
      send(OP_RUN, 4'd0);
      cyc(); cyc();
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      chk("rst_bin", {28'b0, o_bin}, 32'd0);
      chk("rst_gray", {28'b0, o_gray}, 32'd0);
      chk("rst_busy", {31'b0, o_busy}, 32'd0);
      chk("rst_ready", {31'b0, cmd_ready}, 32'd1);
      chk("rst_tick", {31'b0, o_tick}, 32'd0);
      for (int i = 0; i < 12; i++) cyc();
      chk("rst_hold_bin", {28'b0, o_bin}, 32'd0);

      // New RUN after reset: prescaler restarts, first advance exactly 4 edges later
      push(4'd1, 1'b0);
      send(OP_RUN, 4'd0);
      cyc(); cyc(); cyc();
      chk("rerun_pre", {28'b0, o_bin}, 32'd0);
      cyc();
      chk("rerun_bin", {28'b0, o_bin}, 32'd1);
      drained("rerun_drained");
      send(OP_STOP, 4'd0);

      // Reset while in STEP: the pending advance is lost
      send(OP_LOAD, 4'd7);
      send(OP_STEP, 4'd0);
      chk("rst_step_state", {31'b0, cmd_ready}, 32'd0);
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      chk("rst_step_bin", {28'b0, o_bin}, 32'd0);
      chk("rst_step_tick", {31'b0, o_tick}, 32'd0);
      chk("rst_step_ready", {31'b0, cmd_ready}, 32'd1);
      for (int i = 0; i < 4; i++) cyc();
      chk("rst_step_hold", {28'b0, o_bin}, 32'd0);
      drained("final_drained");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gray_cnt_sequencer.md
Name: gray_cnt_sequencer

Overview:
Command-driven controller that sequences a 4-bit Gray-code counter. It accepts RUN, STOP, STEP and LOAD commands over a valid/ready interface. An internal prescaler sets the advance rate; the default gives 1 s per count at 50 MHz. Outputs are the binary and Gray count plus per-advance tick and wrap strobes, for display/LED logic downstream.

Parameters:
TICK_DIV, 50000000, clk cycles per count advance in RUN; legal range 1..2^32-1; prescaler is 32 bits.
CNT_W, 4, counter width; the test plan uses the default only.

Ports:
clk  in  1  system clock (50 MHz)
rst_n  in  1  reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at posedge clk
cmd_op  in  2  00 STOP, 01 RUN, 10 STEP, 11 LOAD
cmd_arg  in  CNT_W  RUN/STEP: bit0 = dir (0 up, 1 down); LOAD: binary value to load
o_bin  out  CNT_W  registered binary count
o_gray  out  CNT_W  Gray encoding of o_bin
o_tick  out  1  one-cycle strobe, count advanced
o_wrap  out  1  one-cycle strobe, count wrapped
o_busy  out  1  high in RUN or STEP state

Behaviour:
- Reset: reset rst_n, synchronous, active-low; clock clk.
- Reset values: state IDLE, o_bin 0, o_gray 0, prescaler 0, dir 0 (up), o_tick 0, o_wrap 0, o_busy 0, cmd_ready 1.
- o_gray = o_bin ^ (o_bin >> 1), combinational from registered o_bin. Zero extra latency.
- cmd_ready = (state != STEP), combinational from state.
- Accept = cmd_valid && cmd_ready at a posedge. Effects are visible after that edge. Unaccepted commands have no effect.
- FSM states: IDLE, RUN, STEP.
  - IDLE: count held; prescaler held at 0.
  - RUN: prescaler counts 0..TICK_DIV-1. At the edge where prescaler == TICK_DIV-1, the count advances in direction dir and the prescaler returns to 0.
  - STEP: one-cycle state. At the next edge the count advances once in dir, then state goes to IDLE.
- Command actions, valid in IDLE or RUN:
  - STOP: state IDLE; prescaler 0; count held.
  - RUN: dir <= cmd_arg[0]; state RUN; prescaler 0. Re-issuing RUN while in RUN restarts the period.
  - STEP: dir <= cmd_arg[0]; state STEP. From RUN, the step is followed by IDLE, not RUN.
  - LOAD: o_bin <= cmd_arg; prescaler 0; state and dir unchanged.
- Simultaneous events: if a command is accepted on the same edge as a prescaler terminal count, the command wins. That cycle's advance, o_tick and o_wrap are suppressed.
- Latency: with RUN accepted at edge N, advances occur at edges N+TICK_DIV, N+2*TICK_DIV, and so on. With TICK_DIV=1 the count advances every edge after N.
- Arithmetic: modulo 2^CNT_W.
  - Up: 15 -> 0 asserts o_wrap.
  - Down: 0 -> 15 asserts o_wrap.
  - LOAD never asserts o_wrap or o_tick.
- o_tick and o_wrap are registered and high for exactly the cycle in which the new o_bin is visible.
- o_busy = (state == RUN || state == STEP).
- Reset mid-operation, in any state including STEP: all registers return to reset values on the next edge. Any pending advance is lost.

Test Plan:
- Reset then idle 20 cycles -> o_bin 0, o_gray 0000, o_tick 0, o_busy 0, cmd_ready 1 throughout.
- TICK_DIV=4; RUN up accepted at edge N -> o_bin 1 after N+4, 2 after N+8, o_tick high one cycle each.
  - Run 16 advances -> o_gray sequence 0001,0011,0010,0110,…,1000,0000.
  - o_wrap high only on 15 -> 0.
- TICK_DIV=4; LOAD 0 then RUN down -> first advance gives o_bin 15, o_gray 1000, o_wrap 1. Next advance gives 14, o_gray 1001, o_wrap 0.
- IDLE with o_bin 5; STEP up -> cmd_ready 0 for one cycle, then o_bin 6, o_gray 0101, o_tick 1, back to IDLE.
  - cmd_valid held during STEP is accepted only when cmd_ready returns to 1.
- TICK_DIV=4 RUN up at o_bin 3; STOP presented on the terminal-count edge -> o_bin stays 3, no o_tick.
  - Same setup with LOAD 9 on the terminal edge -> o_bin 9, no o_tick, next advance 4 cycles later gives 10.
- RUN up with TICK_DIV=4; assert rst_n=0 for one edge mid-period at o_bin 7 -> o_bin 0, state IDLE, prescaler 0; no advance until a new RUN.
